mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Responder (slave) end of the CPU<->RAM request protocol: accepts load/store requests from the
//  memory controller, serves them from an on-chip word array after a configurable number of wait
//  states, and returns load data with a one-cycle ready pulse. Replaces the zero-latency on-chip RAM
//  so that controller stall handling is exercised with realistic latency.
// PARAMETERS
//  ADDR_W       10   word-address width; array depth = 2**ADDR_W words of 32 bits
//  WAIT_CYCLES  2    wait states between request acceptance and ready (0..15)
// PORTS
//  clk    in   1   responder clock (RAM clock domain)
//  nrst   in   1   reset, asynchronous, active-low
//  ren    in   1   load request; held stable until ready
//  wen    in   1   store request; held stable until ready
//  addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//  store  in   32  store data
//  be     in   4   byte enables for store (be[i] writes store[8i+7:8i])
//  load   out  32  load data, valid only while ready=1
//  ready  out  1   one-cycle completion pulse
//  err    out  1   access error, valid with ready (tied 0 without RESP_ERR_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, wait count=0, ready=0, err=0, load=0. Array contents are not reset.
//  - FSM: IDLE -> WAIT when (ren|wen) is sampled in IDLE; WAIT_CYCLES=0 -> IDLE goes straight to RESP.
//    WAIT counts 1..WAIT_CYCLES, then -> RESP. RESP lasts exactly one cycle, then -> IDLE.
//  - Latency: request first seen at edge k -> ready=1 during cycle k+1+WAIT_CYCLES; next request
//    accepted no earlier than the IDLE cycle after RESP (back-to-back period WAIT_CYCLES+2).
//  - Store committed on the edge entering RESP; only lanes with be=1 change; load reads old/updated
//    word (read-after-write within same request returns the new data).
//  - Load: word latched on edge entering RESP; load=0 whenever ready=0.
//  - ren and wen both high: treated as store; load returns the post-write word.
//  - Abort: ren and wen both low during WAIT -> return to IDLE, no write, no ready.
//  - addr/store/be changes during WAIT are a protocol violation; values sampled at RESP entry are used.
//  - Address wrap: bits above ADDR_W+1 ignored (index wraps modulo depth) unless RESP_ERR_EN.
//  - Reset mid-request: immediate return to IDLE, pending store discarded, ready/err low.
// CONFIGURATION
//  RESP_ERR_EN defined: err=1 with ready when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0; store
//  suppressed, load=0. Not defined: err tied 0, low bits ignored, high bits wrap.
// STRUCTURE
//  - rv32ima_pkg gains: word_t reuse, typedef enum logic [1:0] {RESP_IDLE, RESP_WAIT, RESP_RESP}
//    resp_state_t; localparam WAIT_CNT_W=4.
//  - Sub-module mem_responder_array: 2**ADDR_W x 32 byte-lane write-enable array, synchronous
//    write, registered read; FSM and wait counter stay in mem_responder.
// TESTING
//  - Reset, WAIT_CYCLES=2: ren=1 addr=0x0 at edge 0 -> ready pulses exactly in cycle 3, load=0 else.
//  - Store 0xDEADBEEF be=4'hF @0x40, then load @0x40 -> load=0xDEADBEEF, err=0.
//  - Store 0x000000AA be=4'h1 @0x40 over 0xDEADBEEF -> subsequent load returns 0xDEADBEAA.
//  - wen asserted then dropped after 1 cycle in WAIT -> no ready; load @ addr shows old value.
//  - nrst pulsed during WAIT of store 0x12345678 @0x8 -> ready never asserted, word unchanged.
//  - RESP_ERR_EN, load @0x42 -> ready=1, err=1, load=0; without it, @(1<<ADDR_W+2) aliases @0x0.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima memory path: data word, responder FSM states, wait counter width.
package rv32ima_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_WAIT,
    RESP_RESP
  } resp_state_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word array with byte-lane writes and a write-first registered read.
// The read register clears whenever no read is requested, so it can drive the load bus directly.
module mem_responder_array
  import rv32ima_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  word_t             wdata,
  output word_t             rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  word_t mem_q [DEPTH];
  word_t merged_c;
  word_t rdata_d;
  word_t rdata_q;

  // Merge enabled store lanes over the current word; the read sees the merged value.
  always_comb begin
    merged_c = mem_q[idx];
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) merged_c[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    rdata_d = rd_en ? merged_c : '0;
  end

  // Contents are not reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (wr_en && nrst) mem_q[idx] <= merged_c;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Responder end of the CPU<->RAM request protocol with WAIT_CYCLES wait states per request.
// Optional RESP_ERR_EN flags misaligned / out-of-range addresses instead of wrapping them.
module mem_responder
  import rv32ima_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] store,
  input  logic [3:0]  be,
  output logic [31:0] load,
  output logic        ready,
  output logic        err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

  resp_state_t           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  req_c;
  logic                  acc_err_c;
  logic                  go_resp_c;
  logic                  arr_rd_c;
  logic                  arr_wr_c;

  assign req_c = ren | wen;

`ifdef RESP_ERR_EN
  assign acc_err_c = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
`else
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign acc_err_c   = 1'b0;
`endif

  // Next state, wait counter, and the array strobes issued on the edge entering RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    go_resp_c = 1'b0;
    arr_rd_c  = 1'b0;
    arr_wr_c  = 1'b0;

    unique case (state_q)
      RESP_IDLE: begin
        if (req_c) begin
          if (WAIT_CYCLES == 0) begin
            go_resp_c = 1'b1;
          end else begin
            state_d = RESP_WAIT;
            cnt_d   = WAIT_CNT_W'(1);
          end
        end
      end
      RESP_WAIT: begin
        if (!req_c) begin
          state_d = RESP_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= WAIT_LAST) begin
          go_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
      end
      RESP_RESP: begin
        state_d = RESP_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = RESP_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (go_resp_c) begin
      state_d  = RESP_RESP;
      cnt_d    = '0;
      ready_d  = 1'b1;
      err_d    = acc_err_c;
      arr_rd_c = !acc_err_c;
      arr_wr_c = wen && !acc_err_c;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RESP_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  mem_responder_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .nrst  (nrst),
    .rd_en (arr_rd_c),
    .wr_en (arr_wr_c),
    .be    (be),
    .idx   (addr[ADDR_W+1:2]),
    .wdata (store),
    .rdata (load)
  );

  assign ready = ready_q;
  assign err   = err_q;

endmodule
